// File: rtl/xor_accum.sv
// xor_accum: XOR/XNOR/accumulating-XOR unit with valid/ready handshakes and a DEPTH-entry output FIFO.
// Optional XOR_ACCUM_PARITY_EN adds out_parity, the stored reduction XOR of each pushed entry.
module xor_accum #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             acc_busy
`ifdef XOR_ACCUM_PARITY_EN
  ,
  output logic             out_parity
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [1:0] M_XOR = 2'd0, M_XNOR = 2'd1, M_ACC = 2'd2, M_CLR = 2'd3;
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state;
  logic [WIDTH-1:0] acc, acc_next, push_data;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic accept, pop, push;
  assign in_ready = count < FULL;
  assign out_valid = count != '0;
  assign out_data = mem[rd_ptr];
  assign acc_busy = state == ACCUM;
  assign accept = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign acc_next = acc ^ in_a ^ in_b;
  // ACC with last pushes the folded value; non-last ACC and CLR only touch the accumulator
  assign push = accept && (in_mode == M_XOR || in_mode == M_XNOR || (in_mode == M_ACC && in_last));
  assign push_data = in_mode == M_XOR ? in_a ^ in_b : in_mode == M_XNOR ? ~(in_a ^ in_b) : acc_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (accept && in_mode == M_ACC) begin
        acc <= in_last ? '0 : acc_next;
        state <= in_last ? IDLE : ACCUM;
      end else if (accept && in_mode == M_CLR) begin
        acc <= '0;
        state <= IDLE;
      end
    end
  end
`ifdef XOR_ACCUM_PARITY_EN
  logic par [DEPTH];
  assign out_parity = par[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < DEPTH; i++) par[i] <= 1'b0;
    else if (push) par[wr_ptr] <= ^push_data;
  end
`endif
endmodule

// File: tb/tb_xor_accum.sv
// tb_xor_accum: randomized and directed checks of xor_accum against a queue-based reference model.
module tb_xor_accum;
  localparam int W = 32;
  localparam int D = 4;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_last = 0, out_valid, out_ready = 0, acc_busy;
  logic [W-1:0] in_a = 0, in_b = 0, out_data;
  logic [1:0] in_mode = 0;
`ifdef XOR_ACCUM_PARITY_EN
  logic out_parity;
`endif
  int n_checks = 0, n_fail = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] m_acc = 0;
  logic m_busy = 0;
  bit last_acc;

  xor_accum #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .acc_busy(acc_busy)
`ifdef XOR_ACCUM_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic v, input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic l, input logic r);
    bit acc_ok, pop_ok;
    logic [W-1:0] nxt;
    in_valid = v; in_mode = m; in_a = a; in_b = b; in_last = l; out_ready = r;
    acc_ok = v && (q.size() < D);
    pop_ok = r && (q.size() > 0);
    last_acc = acc_ok;
    @(posedge clk); #1;
    if (rst) begin
      q.delete(); m_acc = 0; m_busy = 0;
    end else begin
      if (pop_ok) void'(q.pop_front());
      if (acc_ok) begin
        if (m == 2'd0) q.push_back(a ^ b);
        else if (m == 2'd1) q.push_back(~(a ^ b));
        else if (m == 2'd2) begin
          nxt = m_acc ^ a ^ b;
          if (l) begin q.push_back(nxt); m_acc = 0; m_busy = 0; end
          else begin m_acc = nxt; m_busy = 1; end
        end else begin m_acc = 0; m_busy = 0; end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    rst = 0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (acc_busy !== 1'b0) begin n_fail++; $display("FAIL reset_acc_busy got %b want 0", acc_busy); end
  endtask

  task automatic test_xor();
    cycle(1, 2'd0, 32'h0000_00FF, 32'h0000_0F0F, 0, 0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0FF0) begin
      n_fail++; $display("FAIL xor got v=%b %h want v=1 00000ff0", out_valid, out_data); end
    cycle(1, 2'd1, 32'h0000_00FF, 32'h0000_0F0F, 0, 1);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF_F00F) begin
      n_fail++; $display("FAIL xnor got v=%b %h want v=1 fffff00f", out_valid, out_data); end
    cycle(0, 0, 0, 0, 0, 1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL xor_drain got %b want 0", out_valid); end
  endtask

  task automatic test_acc();
    out_ready = 1;
    cycle(1, 2'd2, 1, 2, 0, 1);
    n_checks++; if (acc_busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL acc_first got busy=%b v=%b want busy=1 v=0", acc_busy, out_valid); end
    cycle(1, 2'd2, 4, 8, 0, 1);
    n_checks++; if (acc_busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL acc_second got busy=%b v=%b want busy=1 v=0", acc_busy, out_valid); end
    cycle(1, 2'd2, 32'h10, 32'h20, 1, 1);
    n_checks++; if (acc_busy !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h3F) begin
      n_fail++; $display("FAIL acc_fold got busy=%b v=%b %h want busy=0 v=1 0000003f", acc_busy, out_valid, out_data); end
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_clr();
    cycle(1, 2'd2, 32'hA, 0, 0, 1);
    cycle(1, 2'd3, 32'hFFFF, 32'h1234, 0, 1);
    n_checks++; if (acc_busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr got busy=%b v=%b want busy=0 v=0", acc_busy, out_valid); end
    cycle(1, 2'd2, 32'h5, 0, 1, 1);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h5) begin
      n_fail++; $display("FAIL clr_acc got v=%b %h want v=1 00000005", out_valid, out_data); end
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e[5];
    logic [W-1:0] got[$];
    int sent = 0;
    for (int i = 0; i < 5; i++) e[i] = W'(32'h1111_0000 * (i + 1)) ^ W'(i * 3);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 2'd0, e[i], 0, 0, 0);
      if (last_acc) sent++;
      if (i == 3) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got in_ready=%b want 0", in_ready); end
      end
    end
    n_checks++; if (sent != 4 || out_data !== e[0]) begin
      n_fail++; $display("FAIL bp_held got sent=%0d head=%h want 4 %h", sent, out_data, e[0]); end
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      if (out_valid) got.push_back(out_data);
      cycle(sent < 5, 2'd0, sent < 5 ? e[sent] : '0, 0, 0, 1);
      if (last_acc) sent++;
    end
    n_checks++; if (got.size() != 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      n_checks++; if (got[i] !== e[i]) begin n_fail++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], e[i]); end
    end
  endtask

  task automatic test_simul();
    cycle(1, 2'd0, 32'hAAAA, 0, 0, 0);
    cycle(1, 2'd1, 32'hBBBB, 0, 0, 0);
    cycle(1, 2'd0, 32'hCCCC, 0, 0, 1);
    n_checks++; if (q.size() != 2 || out_data !== ~32'hBBBB || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL simul got head=%h rdy=%b want %h rdy=1", out_data, in_ready, ~32'hBBBB); end
    cycle(0, 0, 0, 0, 0, 1);
    n_checks++; if (out_data !== 32'hCCCC || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL simul_order got %h v=%b want 0000cccc v=1", out_data, out_valid); end
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 3; i++) cycle(1, 2'd0, W'(i + 7), 0, 0, 0);
    cycle(1, 2'd2, 32'h77, 0, 0, 0);
    rst = 1;
    cycle(1, 2'd0, 32'h1, 0, 0, 1);
    rst = 0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got v=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, acc_busy); end
    cycle(1, 2'd2, 32'h3, 0, 1, 0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h3) begin
      n_fail++; $display("FAIL rst_mid_acc got v=%b %h want v=1 00000003", out_valid, out_data); end
`ifdef XOR_ACCUM_PARITY_EN
    n_checks++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL rst_mid_parity got %b want 0", out_parity); end
`endif
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0);
      n_checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < D) || acc_busy !== m_busy ||
          (q.size() > 0 && out_data !== q[0])) begin
        n_fail++;
        if (bad++ < 10) $display("FAIL random c=%0d got v=%b rdy=%b busy=%b d=%h want v=%b rdy=%b busy=%b d=%h",
          c, out_valid, in_ready, acc_busy, out_data, q.size() > 0, q.size() < D, m_busy,
          q.size() > 0 ? q[0] : '0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_xor();
    test_acc();
    test_clr();
    test_backpressure();
    test_simul();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
